exe_stage_muldiv: RTL
=====================

// Module: exe_stage_muldiv
// PURPOSE
//  Execute stage; consumes the ID/EXE pipeline register outputs.
//  Computes single-cycle ALU ops and iterative 32-bit MUL/DIVU/REMU.
//  Drives a registered result bundle to the EXE/MEM boundary.
//  Raises stall to freeze PC, IF/ID and ID/EXE while a multi-cycle op runs.
// PARAMETERS
//  XLEN   32  datapath width; MUL/DIV iteration count = XLEN
// PORTS
//  clk          in   1     single clock, posedge
//  rst_n        in   1     synchronous reset, active-low
//  valid_in     in   1     ID/EXE register holds a real instruction
//  WB_EN_EXE    in   1     writeback enable
//  MEM_CMD_EXE  in   2     memory command, passed through
//  EXE_CMD_EXE  in   6     operation select
//  Val1_EXE     in   XLEN  operand A
//  Val2_EXE     in   XLEN  operand B
//  Reg2_EXE     in   XLEN  store data, passed through
//  Dst_EXE      in   5     destination register
//  stall        out  1     combinational; upstream holds while 1
//  valid_out    out  1     result bundle valid (registered)
//  WB_EN_MEM    out  1     registered WB enable, forced 0 when !valid_out
//  MEM_CMD_MEM  out  2     registered; forced 0 when !valid_out
//  ALU_Res      out  XLEN  registered result
//  Reg2_MEM     out  XLEN  registered store data
//  Dst_MEM      out  5     registered destination
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): all outputs 0, FSM=IDLE, counter=0; abandons any op in flight.
//  EXE_CMD: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU,
//    16 MUL, 17 DIVU, 18 REMU. Any other code: result 0, normal single-cycle timing.
//  Shifts use Val2[4:0]. ADD/SUB wrap modulo 2^XLEN with no overflow flag.
//  Single-cycle op accepted in IDLE: bundle registered at next edge, latency 1, stall=0.
//  valid_in=0 in IDLE: next edge loads a bubble (valid_out=0, WB_EN_MEM=0, MEM_CMD_MEM=0).
//  FSM states: IDLE, BUSY.
//    IDLE + valid_in + MUL/DIVU/REMU: stall=1; latch operands, control and Dst;
//      counter<=0; -> BUSY; bubble emitted to output.
//    BUSY: one shift-add (MUL) or restoring-subtract (DIVU/REMU) step per cycle.
//      Counter 0..XLEN-1. stall=1 while counter<XLEN-1; stall=0 on the final step.
//      Final step: upstream advances the same edge; block must not re-accept the held copy.
//      Bubbles emitted on all BUSY cycles except the final step.
//    Final step edge: bundle loaded with the result, valid_out=1; -> IDLE.
//    Accept (T0) to valid_out = XLEN+1 cycles; stall high for XLEN cycles (T0..T31).
//  MUL returns the low XLEN bits of the unsigned product.
//  DIVU/REMU by zero: quotient all-ones, remainder = dividend; iteration count is unchanged.
//  In BUSY, valid_in and operand inputs are ignored; only latched copies are used.
// CONFIGURATION
//  EXE_MULDIV_EN defined: iterative MUL/DIVU/REMU unit and BUSY state are built.
//  Not defined: codes 16-18 decode as unknown (result 0, latency 1); stall tied 0.
//    The FSM reduces to IDLE only.
// TESTING
//  ADD 7+5, Dst=3, WB=1 -> next cycle valid_out=1, ALU_Res=12, Dst_MEM=3, stall=0.
//  SUB 0-1 -> ALU_Res=32'hFFFFFFFF. SRA 32'h80000000 by 4 -> 32'hF8000000.
//  SLT -1,1 -> 1. SLTU -1,1 -> 0.
//  MUL 32'h10000 x 32'h10001 -> stall high 32 cycles; valid_out at T33; ALU_Res=32'h10000.
//  DIVU 100/7 -> 14; REMU 100/7 -> 2. DIVU 5/0 -> 32'hFFFFFFFF; REMU 5/0 -> 5.
//  MUL followed by ADD 1+1 held upstream -> ADD result appears the cycle after MUL result.
//    No duplicate MUL result.
//  rst_n=0 at BUSY counter=10 -> next cycle stall=0, valid_out=0.
//    A following ADD completes normally.
//  Build without EXE_MULDIV_EN: MUL 3x4 -> stall=0, ALU_Res=0 after 1 cycle.

Source files
------------

// File: rtl/exe_stage_muldiv.sv
// Execute stage: single-cycle ALU plus an optional iterative 32-step MUL/DIVU/REMU unit.
// Define EXE_MULDIV_EN to build the multi-cycle unit; without it codes 16-18 decode as unknown.
module exe_stage_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic            WB_EN_EXE,
  input  logic [1:0]      MEM_CMD_EXE,
  input  logic [5:0]      EXE_CMD_EXE,
  input  logic [XLEN-1:0] Val1_EXE,
  input  logic [XLEN-1:0] Val2_EXE,
  input  logic [XLEN-1:0] Reg2_EXE,
  input  logic [4:0]      Dst_EXE,
  output logic            stall,
  output logic            valid_out,
  output logic            WB_EN_MEM,
  output logic [1:0]      MEM_CMD_MEM,
  output logic [XLEN-1:0] ALU_Res,
  output logic [XLEN-1:0] Reg2_MEM,
  output logic [4:0]      Dst_MEM
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [5:0] CMD_ADD  = 6'd0;
  localparam logic [5:0] CMD_SUB  = 6'd1;
  localparam logic [5:0] CMD_AND  = 6'd2;
  localparam logic [5:0] CMD_OR   = 6'd3;
  localparam logic [5:0] CMD_XOR  = 6'd4;
  localparam logic [5:0] CMD_SLL  = 6'd5;
  localparam logic [5:0] CMD_SRL  = 6'd6;
  localparam logic [5:0] CMD_SRA  = 6'd7;
  localparam logic [5:0] CMD_SLT  = 6'd8;
  localparam logic [5:0] CMD_SLTU = 6'd9;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state_q, state_d;

  logic            valid_q, valid_d;
  logic            wb_q, wb_d;
  logic [1:0]      mem_cmd_q, mem_cmd_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [XLEN-1:0] reg2_q, reg2_d;
  logic [4:0]      dst_q, dst_d;

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic            is_muldiv;

  assign shamt = Val2_EXE[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (EXE_CMD_EXE)
      CMD_ADD:  alu_res = Val1_EXE + Val2_EXE;
      CMD_SUB:  alu_res = Val1_EXE - Val2_EXE;
      CMD_AND:  alu_res = Val1_EXE & Val2_EXE;
      CMD_OR:   alu_res = Val1_EXE | Val2_EXE;
      CMD_XOR:  alu_res = Val1_EXE ^ Val2_EXE;
      CMD_SLL:  alu_res = Val1_EXE << shamt;
      CMD_SRL:  alu_res = Val1_EXE >> shamt;
      CMD_SRA:  alu_res = $unsigned($signed(Val1_EXE) >>> shamt);
      CMD_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(Val1_EXE) < $signed(Val2_EXE))};
      CMD_SLTU: alu_res = {{(XLEN-1){1'b0}}, (Val1_EXE < Val2_EXE)};
      default:  alu_res = '0;
    endcase
  end

`ifdef EXE_MULDIV_EN
  localparam logic [5:0]     CMD_MUL  = 6'd16;
  localparam logic [5:0]     CMD_DIVU = 6'd17;
  localparam logic [5:0]     CMD_REMU = 6'd18;
  localparam logic [SHW-1:0] LAST     = SHW'(XLEN-1);

  // acc holds the product (MUL) or partial remainder (DIVU/REMU);
  // op_a is the multiplicand or the dividend/quotient shift register.
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [5:0]      op_q, op_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] op_a_q, op_a_d;
  logic [XLEN-1:0] op_b_q, op_b_d;
  logic            hold_wb_q, hold_wb_d;
  logic [1:0]      hold_mem_q, hold_mem_d;
  logic [XLEN-1:0] hold_reg2_q, hold_reg2_d;
  logic [4:0]      hold_dst_q, hold_dst_d;

  logic [XLEN-1:0] step_acc, step_a, step_b, muldiv_res;
  logic [XLEN:0]   rem_shift, rem_diff;

  assign is_muldiv = (EXE_CMD_EXE == CMD_MUL) || (EXE_CMD_EXE == CMD_DIVU) ||
                     (EXE_CMD_EXE == CMD_REMU);

  always_comb begin
    rem_shift = {acc_q, op_a_q[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, op_b_q};
    if (op_q == CMD_MUL) begin
      step_acc = acc_q + (op_b_q[0] ? op_a_q : '0);
      step_a   = op_a_q << 1;
      step_b   = op_b_q >> 1;
    end else if (!rem_diff[XLEN]) begin
      step_acc = rem_diff[XLEN-1:0];
      step_a   = {op_a_q[XLEN-2:0], 1'b1};
      step_b   = op_b_q;
    end else begin
      step_acc = rem_shift[XLEN-1:0];
      step_a   = {op_a_q[XLEN-2:0], 1'b0};
      step_b   = op_b_q;
    end
    muldiv_res = (op_q == CMD_DIVU) ? step_a : step_acc;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    acc_d       = acc_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    hold_wb_d   = hold_wb_q;
    hold_mem_d  = hold_mem_q;
    hold_reg2_d = hold_reg2_q;
    hold_dst_d  = hold_dst_q;
    case (state_q)
      IDLE: begin
        if (valid_in && is_muldiv) begin
          state_d     = BUSY;
          cnt_d       = '0;
          op_d        = EXE_CMD_EXE;
          acc_d       = '0;
          op_a_d      = Val1_EXE;
          op_b_d      = Val2_EXE;
          hold_wb_d   = WB_EN_EXE;
          hold_mem_d  = MEM_CMD_EXE;
          hold_reg2_d = Reg2_EXE;
          hold_dst_d  = Dst_EXE;
        end
      end
      BUSY: begin
        acc_d  = step_acc;
        op_a_d = step_a;
        op_b_d = step_b;
        cnt_d  = cnt_q + SHW'(1);
        // Upstream advances on this edge, so the held copy is never re-accepted.
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
`else
  assign is_muldiv = 1'b0;

  always_comb begin
    state_d = IDLE;
  end
`endif

  always_comb begin
    stall     = 1'b0;
    valid_d   = 1'b0;
    wb_d      = 1'b0;
    mem_cmd_d = 2'b00;
    res_d     = '0;
    reg2_d    = '0;
    dst_d     = '0;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          if (is_muldiv) begin
            stall = 1'b1;
          end else begin
            valid_d   = 1'b1;
            wb_d      = WB_EN_EXE;
            mem_cmd_d = MEM_CMD_EXE;
            res_d     = alu_res;
            reg2_d    = Reg2_EXE;
            dst_d     = Dst_EXE;
          end
        end
      end
      BUSY: begin
`ifdef EXE_MULDIV_EN
        if (cnt_q != LAST) begin
          stall = 1'b1;
        end else begin
          valid_d   = 1'b1;
          wb_d      = hold_wb_q;
          mem_cmd_d = hold_mem_q;
          res_d     = muldiv_res;
          reg2_d    = hold_reg2_q;
          dst_d     = hold_dst_q;
        end
`endif
      end
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      wb_q        <= 1'b0;
      mem_cmd_q   <= 2'b00;
      res_q       <= '0;
      reg2_q      <= '0;
      dst_q       <= '0;
`ifdef EXE_MULDIV_EN
      cnt_q       <= '0;
      op_q        <= '0;
      acc_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      hold_wb_q   <= 1'b0;
      hold_mem_q  <= 2'b00;
      hold_reg2_q <= '0;
      hold_dst_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      wb_q        <= wb_d;
      mem_cmd_q   <= mem_cmd_d;
      res_q       <= res_d;
      reg2_q      <= reg2_d;
      dst_q       <= dst_d;
`ifdef EXE_MULDIV_EN
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      hold_wb_q   <= hold_wb_d;
      hold_mem_q  <= hold_mem_d;
      hold_reg2_q <= hold_reg2_d;
      hold_dst_q  <= hold_dst_d;
`endif
    end
  end

  assign valid_out   = valid_q;
  assign WB_EN_MEM   = wb_q;
  assign MEM_CMD_MEM = mem_cmd_q;
  assign ALU_Res     = res_q;
  assign Reg2_MEM    = reg2_q;
  assign Dst_MEM     = dst_q;

endmodule
